wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Write-back arbiter that drives the register-file write port (rd_we/rd/rd_data).
//  Merges two result sources:
//   - the single-cycle ALU path, which never stalls;
//   - the long-latency LSU/MUL path, which uses a valid/ready handshake.
//  LSU results are buffered in a small FIFO while the ALU holds the port.
//  Keeps a pending-destination bitmap so issue logic can stall on RAW hazards against in-flight long-latency results.
// PARAMETERS
//  XLEN   64  data width of results and rd_data
//  DEPTH  2   LSU result FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1           clock; all state updates on posedge
//  rst_n       in   1           reset, synchronous, active-low
//  alu_valid   in   1           ALU result valid this cycle; cannot be back-pressured
//  alu_rd      in   5           ALU destination register
//  alu_data    in   XLEN        ALU result
//  lsu_valid   in   1           long-latency result offered
//  lsu_ready   out  1           FIFO can accept; transfer occurs when lsu_valid & lsu_ready
//  lsu_rd      in   5           long-latency destination register
//  lsu_data    in   XLEN        long-latency result
//  pend_set    in   1           issue stage dispatched a long-latency op
//  pend_rd     in   5           destination of that op
//  pending     out  32          bit i = write to x(i) outstanding; bit 0 is always 0
//  fifo_count  out  $clog2(DEPTH)+1  occupancy of the LSU FIFO
//  rd_we       out  1           register-file write enable (registered)
//  rd          out  5           register-file write address (registered)
//  rd_data     out  XLEN        register-file write data (registered)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - rd_we=0, rd=0, rd_data=0, pending=0; FIFO emptied (fifo_count=0).
//   - Applies mid-operation: all in-flight results are dropped.
//   - lsu_ready=1 in the first cycle after reset.
//  Selection each cycle:
//   - alu_valid=1: ALU wins.
//   - else FIFO non-empty: FIFO head wins and is popped.
//   - else: nothing is selected.
//  Output register: the selected source is registered into rd/rd_data.
//   - rd_we=1 next cycle only if a source was selected and its rd!=0.
//   - rd=0 results are consumed/popped, but rd_we stays 0.
//  Latency:
//   - ALU: alu_valid at t -> rd_we at t+1.
//   - LSU: handshake at t -> enqueued at t+1 -> earliest rd_we at t+2.
//   - Every cycle alu_valid=1 delays the FIFO head by one cycle.
//  lsu_ready = (fifo_count < DEPTH), derived from current state only; no same-cycle pop credit.
//   - When full, push is refused even if a pop happens that cycle.
//  FIFO is strictly in order; pointers wrap modulo DEPTH.
//   - Simultaneous push and pop leaves the count unchanged.
//  Pending bitmap:
//   - Set: pend_set=1 & pend_rd!=0 sets bit pend_rd at the next edge.
//   - Clear: bit lsu-rd is cleared on the edge where a popped FIFO entry with rd!=0 is registered to the output.
//   - ALU writes never touch pending.
//   - Set and clear of the same bit on the same edge: set wins.
//   - pend_rd=0 is ignored.
//  ALU results are never buffered, so no ALU result is ever lost.
//  The ALU may starve the FIFO indefinitely; issue logic bounds this (not checked here).
// TESTING
//  T1 reset: hold rst_n=0 two cycles with traffic active -> rd_we=0, pending=0, fifo_count=0, lsu_ready=1.
//  T2 ALU: alu_valid=1, alu_rd=5, alu_data=0x1234 at t -> at t+1 rd_we=1, rd=5, rd_data=0x1234; alu_rd=0 at t -> rd_we=0.
//  T3 LSU bypass: pend_set rd=7 at t0 -> pending[7]=1.
//   - LSU handshake rd=7, data=0xAA at t1 (no ALU).
//   - -> rd_we=1, rd=7 at t1+2; pending[7]=0 the same edge.
//  T4 contention/full: alu_valid=1 for 4 cycles while LSU pushes rd=1,2,3.
//   - -> lsu_ready=0 after 2 pushes; rd=3 accepted only after the ALU stops.
//   - -> writes x1,x2,x3 follow the ALU writes, in order, back-to-back.
//  T5 set/clear race: pend_set rd=9 on the same edge x9's LSU result is written -> pending[9] stays 1.
//  T6 reset mid-op: FIFO holding 2 entries, rst_n=0 one cycle -> entries never written; fifo_count=0, pending=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Write-back arbiter for the register-file write port. The single-cycle ALU
//   path always has priority and is never buffered. Long-latency (LSU/MUL)
//   results arrive through a valid/ready handshake and wait in a small
//   in-order FIFO until the ALU leaves the port free. A pending-destination
//   bitmap tracks in-flight long-latency writes so that issue logic can stall
//   on RAW hazards.
//
// Ports
//   clk, rst_n               clock; synchronous active-low reset
//   alu_valid/alu_rd/alu_data  ALU result (no back-pressure)
//   lsu_valid/lsu_ready       long-latency handshake
//   lsu_rd/lsu_data           long-latency result
//   pend_set/pend_rd          issue stage dispatched a long-latency op to pend_rd
//   pending                   bit i set while a long-latency write to x(i) is outstanding
//   fifo_count                current LSU FIFO occupancy
//   rd_we/rd/rd_data          registered register-file write port
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     pend_set,
  input  logic [4:0]               pend_rd,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     rd_we,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pending_q, pending_d;
  logic              rd_we_q, rd_we_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;

  entry_t            head;
  logic              push;
  logic              pop;

  // Ready depends only on registered occupancy: a pop in the same cycle does
  // not free a slot for a push until the next cycle.
  assign lsu_ready = (count_q < DEPTH_CNT);
  assign push      = lsu_valid & lsu_ready;
  assign head      = mem_q[rd_ptr_q];
  // The FIFO only drains in cycles the ALU leaves the port idle.
  assign pop       = ~alu_valid & (count_q != '0);

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{rd: lsu_rd, data: lsu_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Source selection into the output register. A selected result with rd=0
  // is still consumed, but never raises the write enable. With nothing
  // selected the address/data registers simply hold.
  always_comb begin
    rd_we_d   = 1'b0;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    if (alu_valid) begin
      rd_we_d   = (alu_rd != 5'd0);
      rd_d      = alu_rd;
      rd_data_d = alu_data;
    end else if (pop) begin
      rd_we_d   = (head.rd != 5'd0);
      rd_d      = head.rd;
      rd_data_d = head.data;
    end
  end

  // Pending bitmap: clear is applied before set so that a new dispatch to
  // the same register on the retiring edge keeps the bit set. x0 never pends.
  always_comb begin
    pending_d = pending_q;
    if (pop && (head.rd != 5'd0)) begin
      pending_d[head.rd] = 1'b0;
    end
    if (pend_set && (pend_rd != 5'd0)) begin
      pending_d[pend_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops every in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rd_we_q   <= 1'b0;
      rd_q      <= '0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_we_q   <= rd_we_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign pending    = pending_q;
  assign fifo_count = count_q;
  assign rd_we      = rd_we_q;
  assign rd         = rd_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter (XLEN=64, DEPTH=2). A queue-based
//   reference model predicts each cycle's registered outputs into a
//   scoreboard queue when stimulus is driven; the prediction is popped and
//   compared one time step after the clock edge. Table vectors and targeted
//   sequences add hand-computed expectations for the corner cases.
module tb_wb_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [4:0]       lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             pend_set;
  logic [4:0]       pend_rd;
  logic [31:0]      pending;
  logic [1:0]       fifo_count;
  logic             rd_we;
  logic [4:0]       rd;
  logic [XLEN-1:0]  rd_data;

  wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .pend_set   (pend_set),
    .pend_rd    (pend_rd),
    .pending    (pending),
    .fifo_count (fifo_count),
    .rd_we      (rd_we),
    .rd         (rd),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rst_n;
    logic             alu_v;
    logic [4:0]       alu_rd;
    logic [XLEN-1:0]  alu_data;
    logic             lsu_v;
    logic [4:0]       lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    logic             pset;
    logic [4:0]       prd;
  } stim_t;

  typedef struct {
    stim_t            s;
    logic             exp_we;
    logic [4:0]       exp_rd;
    logic [XLEN-1:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
  } ent_t;

  typedef struct {
    logic             we;
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
    logic             cmp_rd;
    logic [31:0]      pend;
    int               count;
    logic             ready;
  } exp_t;

  ent_t        model_fifo[$];
  logic [31:0] model_pend;
  exp_t        exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t mk(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                               input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                               input logic ps, input logic [4:0] pr);
    stim_t s;
    s.rst_n    = 1'b1;
    s.alu_v    = av;
    s.alu_rd   = ar;
    s.alu_data = ad;
    s.lsu_v    = lv;
    s.lsu_rd   = lr;
    s.lsu_data = ld;
    s.pset     = ps;
    s.prd      = pr;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0, 5'd0);
  endfunction

  // Pop the prediction for the edge just taken and compare all outputs.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("rd_we", {63'd0, rd_we}, {63'd0, e.we});
    if (e.cmp_rd) begin
      check("rd", {59'd0, rd}, {59'd0, e.rd});
      check("rd_data", rd_data, e.data);
    end
    check("pending", {32'd0, pending}, {32'd0, e.pend});
    check("fifo_count", {62'd0, fifo_count}, 64'(e.count));
    check("lsu_ready", {63'd0, lsu_ready}, {63'd0, e.ready});
  endtask

  // Drive one cycle of inputs, predict the post-edge state, take the edge,
  // then compare away from the edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    ent_t f;
    logic push;
    rst_n     = s.rst_n;
    alu_valid = s.alu_v;
    alu_rd    = s.alu_rd;
    alu_data  = s.alu_data;
    lsu_valid = s.lsu_v;
    lsu_rd    = s.lsu_rd;
    lsu_data  = s.lsu_data;
    pend_set  = s.pset;
    pend_rd   = s.prd;

    e.we = 1'b0; e.rd = '0; e.data = '0; e.cmp_rd = 1'b0;
    push = s.lsu_v && (model_fifo.size() < DEPTH);
    if (!s.rst_n) begin
      model_fifo.delete();
      model_pend = '0;
      e.cmp_rd   = 1'b1;
    end else begin
      if (s.alu_v) begin
        e.we = (s.alu_rd != 0); e.rd = s.alu_rd; e.data = s.alu_data; e.cmp_rd = 1'b1;
      end else if (model_fifo.size() > 0) begin
        f = model_fifo.pop_front();
        e.we = (f.rd != 0); e.rd = f.rd; e.data = f.data; e.cmp_rd = 1'b1;
        if (f.rd != 0) model_pend[f.rd] = 1'b0;
      end
      if (s.pset && s.prd != 0) model_pend[s.prd] = 1'b1;
      if (push) begin
        f.rd = s.lsu_rd; f.data = s.lsu_data;
        model_fifo.push_back(f);
      end
    end
    e.pend  = model_pend;
    e.count = model_fifo.size();
    e.ready = (model_fifo.size() < DEPTH);
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    checkOutput();
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stim_t s;
    int    idx;
    logic  [4:0] t4_rd    [7];
    logic        t4_ready [7];

    model_pend = '0;
    vecs[0] = '{s: mk(1'b1, 5'd5,  64'h1234, 1'b0, 5'd0, '0, 1'b0, 5'd0), exp_we: 1'b1, exp_rd: 5'd5,  exp_data: 64'h1234};
    vecs[1] = '{s: mk(1'b1, 5'd0,  64'hdead, 1'b0, 5'd0, '0, 1'b0, 5'd0), exp_we: 1'b0, exp_rd: 5'd0,  exp_data: 64'h0};
    vecs[2] = '{s: mk(1'b1, 5'd31, '1,       1'b0, 5'd0, '0, 1'b0, 5'd0), exp_we: 1'b1, exp_rd: 5'd31, exp_data: '1};
    vecs[3] = '{s: idle(),                                                exp_we: 1'b0, exp_rd: 5'd0,  exp_data: 64'h0};
    vecs[4] = '{s: mk(1'b1, 5'd1,  64'h0,    1'b0, 5'd0, '0, 1'b0, 5'd0), exp_we: 1'b1, exp_rd: 5'd1,  exp_data: 64'h0};
    vecs[5] = '{s: mk(1'b1, 5'd17, 64'h0123456789abcdef, 1'b0, 5'd0, '0, 1'b0, 5'd0), exp_we: 1'b1, exp_rd: 5'd17, exp_data: 64'h0123456789abcdef};

    // T1: reset held two cycles with traffic present.
    s = mk(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, 1'b1, 5'd6);
    s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(s);
    check("t1_rd_we", {63'd0, rd_we}, 64'd0);
    check("t1_rd", {59'd0, rd}, 64'd0);
    check("t1_rd_data", rd_data, 64'd0);
    check("t1_pending", {32'd0, pending}, 64'd0);
    check("t1_count", {62'd0, fifo_count}, 64'd0);
    check("t1_ready", {63'd0, lsu_ready}, 64'd1);

    // T2 and simple ALU patterns from the vector table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      check("vec_we", {63'd0, rd_we}, {63'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check("vec_rd", {59'd0, rd}, {59'd0, vecs[i].exp_rd});
        check("vec_data", rd_data, vecs[i].exp_data);
      end
    end

    // T3: LSU result through an empty FIFO, clearing its pending bit.
    applyStimulus(mk(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd7));
    check("t3_pend_set", {63'd0, pending[7]}, 64'd1);
    applyStimulus(mk(1'b0, 5'd0, '0, 1'b1, 5'd7, 64'hAA, 1'b0, 5'd0));
    check("t3_no_early_we", {63'd0, rd_we}, 64'd0);
    check("t3_enqueued", {62'd0, fifo_count}, 64'd1);
    applyStimulus(idle());
    check("t3_we", {63'd0, rd_we}, 64'd1);
    check("t3_rd", {59'd0, rd}, 64'd7);
    check("t3_data", rd_data, 64'hAA);
    check("t3_pend_clr", {63'd0, pending[7]}, 64'd0);

    // T4: ALU holds the port for four cycles while three LSU results queue.
    t4_rd    = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
    t4_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      check("t4_ready", {63'd0, lsu_ready}, {63'd0, t4_ready[i]});
      s = mk(i < 4, 5'(10 + i), 64'(32'hA0 + i), idx < 3, 5'(idx + 1), 64'(32'hB0 + idx), 1'b0, 5'd0);
      applyStimulus(s);
      if (s.lsu_v && t4_ready[i]) idx++;
      check("t4_we", {63'd0, rd_we}, 64'd1);
      check("t4_rd", {59'd0, rd}, {59'd0, t4_rd[i]});
    end
    check("t4_drained", {62'd0, fifo_count}, 64'd0);

    // T5: a new dispatch to x9 on the edge x9's old result retires.
    applyStimulus(mk(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9));
    applyStimulus(mk(1'b0, 5'd0, '0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0));
    applyStimulus(mk(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1, 5'd9));
    check("t5_we", {63'd0, rd_we}, 64'd1);
    check("t5_rd", {59'd0, rd}, 64'd9);
    check("t5_pend_kept", {63'd0, pending[9]}, 64'd1);

    // Random mixed traffic against the model, then drain.
    for (int i = 0; i < 300; i++) begin
      s = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
             ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)));
      applyStimulus(s);
    end
    for (int i = 0; i < 4; i++) applyStimulus(idle());

    // T6: reset drops two buffered results.
    applyStimulus(mk(1'b1, 5'd20, 64'h20, 1'b1, 5'd4, 64'h4, 1'b1, 5'd4));
    applyStimulus(mk(1'b1, 5'd21, 64'h21, 1'b1, 5'd5, 64'h5, 1'b1, 5'd5));
    check("t6_full", {62'd0, fifo_count}, 64'd2);
    s = mk(1'b1, 5'd22, 64'h22, 1'b1, 5'd6, 64'h6, 1'b0, 5'd0);
    s.rst_n = 1'b0;
    applyStimulus(s);
    check("t6_count", {62'd0, fifo_count}, 64'd0);
    check("t6_pending", {32'd0, pending}, 64'd0);
    check("t6_rd_we", {63'd0, rd_we}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(idle());
      check("t6_no_write", {63'd0, rd_we}, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
